// File: rtl/isdu_core.sv
// Instruction sequencing and decode FSM: fetch, decode and a small instruction subset with pause support.
// Control outputs are registered and decoded from the state being entered, so they always match the current state.
module isdu_core (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [3:0] {
        HALTED = 4'd0,
        S18    = 4'd1,
        S33_1  = 4'd2,
        S33_2  = 4'd3,
        S35    = 4'd4,
        S32    = 4'd5,
        S01    = 4'd6,
        S05    = 4'd7,
        S09    = 4'd8,
        S00    = 4'd9,
        S22    = 4'd10,
        S12    = 4'd11,
        PAUSE1 = 4'd12,
        PAUSE2 = 4'd13
    } state_t;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = 24'h000000;

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_r;
    ctrl_t  ctrl_s;

    // State and control-output registers; Reset wins over every other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= HALTED;
            ctrl_r  <= CTRL_NONE;
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_s;
        end
    end

    // Next-state selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            HALTED: begin
                if (Run) begin
                    next_state_s = S18;
                end else begin
                    next_state_s = HALTED;
                end
            end
            S18:   next_state_s = S33_1;
            S33_1: next_state_s = S33_2;
            S33_2: next_state_s = S35;
            S35:   next_state_s = S32;
            S32: begin
                case (Opcode)
                    4'b0001: next_state_s = S01;
                    4'b0101: next_state_s = S05;
                    4'b1001: next_state_s = S09;
                    4'b0000: next_state_s = S00;
                    4'b1100: next_state_s = S12;
                    4'b1101: next_state_s = PAUSE1;
                    default: next_state_s = S18;
                endcase
            end
            // BEN here is the value latched while in S32
            S00: begin
                if (BEN) begin
                    next_state_s = S22;
                end else begin
                    next_state_s = S18;
                end
            end
            S01, S05, S09, S22, S12: next_state_s = S18;
            PAUSE1: begin
                if (Continue) begin
                    next_state_s = PAUSE2;
                end else begin
                    next_state_s = PAUSE1;
                end
            end
            PAUSE2: begin
                if (Continue) begin
                    next_state_s = PAUSE2;
                end else begin
                    next_state_s = S18;
                end
            end
            default: next_state_s = HALTED;
        endcase
    end

    // Control decode for the state about to be entered.
    always_comb begin
        ctrl_s = CTRL_NONE;
        case (next_state_s)
            S18: begin
                ctrl_s.gate_pc = 1'b1;
                ctrl_s.ld_mar  = 1'b1;
                ctrl_s.pcmux   = 2'b00;
                ctrl_s.ld_pc   = 1'b1;
            end
            S33_1: ctrl_s.mem_oe = 1'b1;
            S33_2: begin
                ctrl_s.mem_oe = 1'b1;
                ctrl_s.ld_mdr = 1'b1;
            end
            S35: begin
                ctrl_s.gate_mdr = 1'b1;
                ctrl_s.ld_ir    = 1'b1;
            end
            S32: ctrl_s.ld_ben = 1'b1;
            S01, S05: begin
                ctrl_s.sr2mux   = IR_5;
                ctrl_s.aluk     = (next_state_s == S05) ? 2'b01 : 2'b00;
                ctrl_s.gate_alu = 1'b1;
                ctrl_s.ld_reg   = 1'b1;
                ctrl_s.ld_cc    = 1'b1;
            end
            S09: begin
                ctrl_s.aluk     = 2'b10;
                ctrl_s.gate_alu = 1'b1;
                ctrl_s.ld_reg   = 1'b1;
                ctrl_s.ld_cc    = 1'b1;
            end
            S22: begin
                ctrl_s.addr1mux = 1'b0;
                ctrl_s.addr2mux = 2'b10;
                ctrl_s.pcmux    = 2'b10;
                ctrl_s.ld_pc    = 1'b1;
            end
            S12: begin
                ctrl_s.addr1mux = 1'b1;
                ctrl_s.addr2mux = 2'b00;
                ctrl_s.pcmux    = 2'b10;
                ctrl_s.ld_pc    = 1'b1;
            end
            PAUSE1: ctrl_s.ld_led = 1'b1;
            default: ctrl_s = CTRL_NONE;
        endcase
    end

    assign LD_MAR     = ctrl_r.ld_mar;
    assign LD_MDR     = ctrl_r.ld_mdr;
    assign LD_IR      = ctrl_r.ld_ir;
    assign LD_BEN     = ctrl_r.ld_ben;
    assign LD_CC      = ctrl_r.ld_cc;
    assign LD_REG     = ctrl_r.ld_reg;
    assign LD_PC      = ctrl_r.ld_pc;
    assign LD_LED     = ctrl_r.ld_led;
    assign GatePC     = ctrl_r.gate_pc;
    assign GateMDR    = ctrl_r.gate_mdr;
    assign GateALU    = ctrl_r.gate_alu;
    assign GateMARMUX = ctrl_r.gate_marmux;
    assign PCMUX      = ctrl_r.pcmux;
    assign ADDR1MUX   = ctrl_r.addr1mux;
    assign ADDR2MUX   = ctrl_r.addr2mux;
    assign ALUK       = ctrl_r.aluk;
    assign DRMUX      = ctrl_r.drmux;
    assign SR1MUX     = ctrl_r.sr1mux;
    assign SR2MUX     = ctrl_r.sr2mux;
    assign Mem_OE     = ctrl_r.mem_oe;
    assign Mem_WE     = ctrl_r.mem_we;

endmodule
